// File: rtl/lumi_txcrdt_pkg.sv
// Shared LUMI credit definitions: FSM encoding, counter width, status field offsets.
package lumi_txcrdt_pkg;

  localparam int LUMI_CRDTW    = 16;
  localparam int STAT_REQ_LSB  = 0;
  localparam int STAT_RESP_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } crdt_state_e;

  function automatic logic [LUMI_CRDTW-1:0] sat_inc(input logic [LUMI_CRDTW-1:0] v,
                                                    input logic                  inc);
    return (inc && (v != '1)) ? v + LUMI_CRDTW'(1) : v;
  endfunction

endpackage

// File: rtl/lumi_crdt_cnt.sv
// Saturating credit counter: adds a value and optionally takes one, never below 0.
module lumi_crdt_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         i_clr,
  input  logic [W-1:0] i_add,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_dec;
  logic [W:0]   w_sum;

  // A decrement on an empty counter is dropped, so the sum can never go negative.
  assign w_dec = i_dec && (r_cnt != '0);
  assign w_sum = {1'b0, r_cnt} + {1'b0, i_add} - {{W{1'b0}}, w_dec};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)    r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= w_sum[W] ? '1 : w_sum[W-1:0];
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/lumi_txcrdt.sv
// LUMI tx credit tracker and periodic rx credit-return message generator.
// States: IDLE disabled | INIT advertise buffer depth | WAIT interval timer | SEND return credits
module lumi_txcrdt
  import lumi_txcrdt_pkg::*;
#(
  parameter int CRDTW = LUMI_CRDTW
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               csr_txcrdt_en,
  input  logic [CRDTW-1:0]   csr_txcrdt_intrvl,
  input  logic [CRDTW-1:0]   csr_rxcrdt_req_init,
  input  logic [CRDTW-1:0]   csr_rxcrdt_resp_init,
  output logic [2*CRDTW-1:0] csr_txcrdt_status,
  input  logic               tx_req_send,
  input  logic               tx_resp_send,
  output logic               tx_req_ok,
  output logic               tx_resp_ok,
  input  logic               rmt_crdt_valid,
  input  logic [CRDTW-1:0]   rmt_crdt_req,
  input  logic [CRDTW-1:0]   rmt_crdt_resp,
  input  logic               rx_req_pop,
  input  logic               rx_resp_pop,
  output logic               crdt_upd_valid,
  output logic [CRDTW-1:0]   crdt_upd_req,
  output logic [CRDTW-1:0]   crdt_upd_resp,
  input  logic               crdt_upd_ready
);

  crdt_state_e      r_state;
  logic [CRDTW-1:0] r_timer;
  logic [CRDTW-1:0] r_ret_req;
  logic [CRDTW-1:0] r_ret_resp;
  logic [CRDTW-1:0] w_req_crdt;
  logic [CRDTW-1:0] w_resp_crdt;
  logic [CRDTW-1:0] w_req_add;
  logic [CRDTW-1:0] w_resp_add;
  logic             w_clr;
  logic             w_send_hs;

  assign w_clr     = !csr_txcrdt_en || (r_state == ST_IDLE);
  assign w_send_hs = csr_txcrdt_en && (r_state == ST_SEND) && crdt_upd_ready;
  assign w_req_add  = rmt_crdt_valid ? rmt_crdt_req  : '0;
  assign w_resp_add = rmt_crdt_valid ? rmt_crdt_resp : '0;

  lumi_crdt_cnt #(.W(CRDTW)) u_req_cnt (
    .clk    (clk),
    .nreset (nreset),
    .i_clr  (w_clr),
    .i_add  (w_req_add),
    .i_dec  (tx_req_send),
    .o_cnt  (w_req_crdt)
  );

  lumi_crdt_cnt #(.W(CRDTW)) u_resp_cnt (
    .clk    (clk),
    .nreset (nreset),
    .i_clr  (w_clr),
    .i_add  (w_resp_add),
    .i_dec  (tx_resp_send),
    .o_cnt  (w_resp_crdt)
  );

  assign csr_txcrdt_status[STAT_REQ_LSB  +: CRDTW] = w_req_crdt;
  assign csr_txcrdt_status[STAT_RESP_LSB +: CRDTW] = w_resp_crdt;
  assign tx_req_ok  = |w_req_crdt;
  assign tx_resp_ok = |w_resp_crdt;

  // Pops landing in the handshake cycle are folded in with the subtraction, not lost.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ret_req  <= '0;
      r_ret_resp <= '0;
    end else if (w_clr) begin
      r_ret_req  <= '0;
      r_ret_resp <= '0;
    end else if (w_send_hs) begin
      r_ret_req  <= sat_inc(r_ret_req  - crdt_upd_req,  rx_req_pop);
      r_ret_resp <= sat_inc(r_ret_resp - crdt_upd_resp, rx_resp_pop);
    end else begin
      r_ret_req  <= sat_inc(r_ret_req,  rx_req_pop);
      r_ret_resp <= sat_inc(r_ret_resp, rx_resp_pop);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      crdt_upd_valid <= 1'b0;
      crdt_upd_req   <= '0;
      crdt_upd_resp  <= '0;
    end else if (!csr_txcrdt_en) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      crdt_upd_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state        <= ST_INIT;
          crdt_upd_valid <= 1'b1;
          crdt_upd_req   <= csr_rxcrdt_req_init;
          crdt_upd_resp  <= csr_rxcrdt_resp_init;
        end
        ST_INIT: begin
          if (crdt_upd_ready) begin
            r_state        <= ST_WAIT;
            crdt_upd_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (r_timer == csr_txcrdt_intrvl) begin
            r_timer <= '0;
            if ((r_ret_req | r_ret_resp) != '0) begin
              r_state        <= ST_SEND;
              crdt_upd_valid <= 1'b1;
              crdt_upd_req   <= r_ret_req;
              crdt_upd_resp  <= r_ret_resp;
            end
          end else begin
            r_timer <= r_timer + CRDTW'(1);
          end
        end
        ST_SEND: begin
          if (crdt_upd_ready) begin
            r_state        <= ST_WAIT;
            crdt_upd_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
